mdr_engine: RTL
===============

# mdr_engine

Parametrised sequential multiply / divide / square-root engine for the MDR datapath. It runs a load handshake to capture operands X and Y from a shared data bus, then iterates one bit per cycle using an internal shift/add/subtract datapath. It returns a double-width result and a remainder with a ready pulse, and flags illegal requests. Width is a parameter. Square root is an optional compile-time feature.

## Interface
- DW, 16: operand width in bits. Must be even and ≥ 4.
- CW, $clog2(DW)+1: iteration counter width. Derived; do not override.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_start  input  1  request a new operation; accepted only in IDLE.
- i_load  input  1  operand strobe; valid only while o_load_x or o_load_y is high.
- i_data  input  DW  operand bus, unsigned.
- i_op  input  2  operation select: 00 mult, 01 div, 10 root, 11 reserved. Sampled when i_start is accepted.
- o_load_x  output  1  engine waiting for X.
- o_load_y  output  1  engine waiting for Y.
- o_result  output  2*DW  mult: product; div: quotient, zero-extended; root: floor(sqrt(X)), zero-extended.
- o_remainder  output  DW  div: X mod Y; root: X − root²; mult: 0.
- o_ready  output  1  one-cycle pulse when o_result and o_remainder become valid.
- o_error  output  1  sticky error flag.

## Operation
- States: IDLE, LOAD_X, LOAD_Y, RUN, DONE, ERR.
- IDLE, i_start=1:
  - i_op is latched, o_error clears, next state is LOAD_X.
  - If op=11, or op=10 with the root feature compiled out, next state is ERR instead.
- LOAD_X: o_load_x=1. When i_load=1, i_data is captured into X.
  - Root goes to RUN; mult and div go to LOAD_Y.
- LOAD_Y: o_load_y=1. When i_load=1, i_data is captured into Y.
  - Div with Y=0 goes to ERR; otherwise next state is RUN.
- RUN: the counter loads N and decrements each cycle. Exit to DONE when the counter reaches 0.
  - N = DW for mult and div; N = DW/2 for root.
- Mult: shift-add, LSB of Y first, into a 2*DW accumulator.
- Div: restoring division, MSB of X first, with a DW+1 partial remainder.
- Root: digit-by-digit, 2 bits of X per cycle, with a DW/2+2 bit trial remainder.
- DONE: o_result and o_remainder are updated, o_ready=1 for one cycle, then IDLE.
  - Outputs hold their values until the next DONE.
- ERR: o_error is set, o_result and o_remainder are forced to 0, then IDLE.
  - o_error stays high until the next accepted i_start or a reset.
- Ignored inputs:
  - i_start outside IDLE.
  - i_load outside LOAD_X and LOAD_Y.
  - i_op changes after acceptance.
- i_start and i_load high together in IDLE: only i_start acts. X is not captured that cycle.
- Arithmetic is unsigned and never overflows: the product fits 2*DW, quotient ≤ X, root < 2^(DW/2).

## Timing
- Reset values: state IDLE; o_load_x=0, o_load_y=0, o_result=0, o_remainder=0, o_ready=0, o_error=0; counter 0.
- i_start accepted at edge t: o_load_x is high from t+1.
- The i_load edge that captures the last operand is L. RUN occupies L+1 to L+N, and o_ready is high during cycle L+N+1.
  - Latency is DW+1 cycles for mult/div and DW/2+1 for root.
- Error path: i_start at t (bad op) gives o_error high from t+2. A divide-by-zero Y captured at L gives o_error high from L+2. No o_ready pulse in either case.
- Back-to-back: i_start may be asserted in the cycle after o_ready. It is accepted because the state is already IDLE.
- Asserting rst in any state returns to reset values immediately. No partial result is retained.

## Configuration
- MDR_ROOT_EN defined: the root datapath and op=10 are supported.
- MDR_ROOT_EN undefined: no root logic is synthesised. op=10 takes the ERR path exactly like op=11. Mult and div timing is unchanged.

## Test plan
- DW=16, mult, X=0x1234, Y=0x0056 -> o_ready 17 cycles after the Y load; o_result=0x00061D78, o_remainder=0.
- Div, X=1000, Y=7 -> o_result=142, o_remainder=6, o_ready after 17 cycles. Then div X=5, Y=0 -> o_error=1, o_result=0, no o_ready.
- Root (MDR_ROOT_EN), X=1000 -> o_load_y never asserts; o_result=31, o_remainder=39, o_ready 9 cycles after the X load. Also X=0xFFFF -> 255, remainder 510.
- op=11 -> o_error high 2 cycles after i_start, o_load_x stays 0. The next valid i_start clears o_error.
- rst pulsed in mid-RUN of a mult -> all outputs are 0 at once; a fresh div 100/10 then gives 10 remainder 0.
- Rebuild without MDR_ROOT_EN, op=10 -> o_error=1. Also i_load pulses in IDLE and during RUN -> no effect on results.

Source files
------------

// File: rtl/mdr_engine.sv
// Sequential multiply / divide / square-root engine, one result bit (root: one digit) per cycle.
// Define MDR_ROOT_EN to build the square-root datapath and accept op=10.
module mdr_engine #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = $clog2(DW) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_load,
  input  logic [DW-1:0]   i_data,
  input  logic [1:0]      i_op,
  output logic            o_load_x,
  output logic            o_load_y,
  output logic [2*DW-1:0] o_result,
  output logic [DW-1:0]   o_remainder,
  output logic            o_ready,
  output logic            o_error
);
  localparam int unsigned HW = DW / 2;
`ifdef MDR_ROOT_EN
  localparam int unsigned RW = HW + 2;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, RUN, DONE, ERR} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_ROOT = 2'b10, OP_RSV = 2'b11} op_t;

  state_t          state, state_d;
  op_t             op;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   x_q, y_q;
  // mult: {partial product, multiplier}; div: dividend/quotient in low half; root: X shifted out MSB-first
  logic [2*DW-1:0] acc, acc_n;
  logic [DW-1:0]   rem, rem_n;
  logic            op_ok, last;
  logic [DW-1:0]   mul_add;
  logic [DW:0]     mul_sum, div_sh;
  logic            div_ge;
`ifdef MDR_ROOT_EN
  logic [HW-1:0]   root, root_n;
  logic [RW-1:0]   rt_trial, rt_test;
`endif

  always_comb begin
`ifdef MDR_ROOT_EN
    op_ok = (i_op != 2'b11);
`else
    op_ok = ~i_op[1];
`endif
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (i_start) state_d = op_ok ? LOAD_X : ERR;
      LOAD_X:  if (i_load) state_d = (op == OP_ROOT) ? RUN : LOAD_Y;
      LOAD_Y:  if (i_load) state_d = (op == OP_DIV && i_data == '0) ? ERR : RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration of the selected algorithm
  always_comb begin
    acc_n   = acc;
    rem_n   = rem;
    mul_add = acc[0] ? x_q : '0;
    mul_sum = {1'b0, acc[2*DW-1:DW]} + {1'b0, mul_add};
    div_sh  = {rem, acc[DW-1]};
    div_ge  = (div_sh >= {1'b0, y_q});
`ifdef MDR_ROOT_EN
    root_n   = root;
    rt_trial = {rem[RW-3:0], acc[DW-1:DW-2]};
    rt_test  = {root, 2'b01};
`endif
    case (op)
      OP_MUL: acc_n = {mul_sum, acc[DW-1:1]};
      OP_DIV: begin
        acc_n = {acc[2*DW-1:DW], acc[DW-2:0], div_ge};
        rem_n = div_ge ? DW'(div_sh - {1'b0, y_q}) : div_sh[DW-1:0];
      end
`ifdef MDR_ROOT_EN
      OP_ROOT: begin
        acc_n = {acc[2*DW-1:DW], acc[DW-3:0], 2'b00};
        if (rt_trial >= rt_test) begin
          rem_n  = DW'(rt_trial - rt_test);
          root_n = {root[HW-2:0], 1'b1};
        end else begin
          rem_n  = DW'(rt_trial);
          root_n = {root[HW-2:0], 1'b0};
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op  <= OP_MUL;
      cnt <= '0;
      x_q <= '0;
      y_q <= '0;
      acc <= '0;
      rem <= '0;
`ifdef MDR_ROOT_EN
      root <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (i_start) op <= op_t'(i_op);
        LOAD_X: if (i_load) begin
          x_q <= i_data;
          acc <= {DW'(0), i_data};
          rem <= '0;
          cnt <= CW'(HW);
`ifdef MDR_ROOT_EN
          root <= '0;
`endif
        end
        LOAD_Y: if (i_load) begin
          y_q <= i_data;
          acc <= {DW'(0), (op == OP_MUL) ? i_data : x_q};
          rem <= '0;
          cnt <= CW'(DW);
        end
        RUN: begin
          acc <= acc_n;
          rem <= rem_n;
          cnt <= cnt - CW'(1);
`ifdef MDR_ROOT_EN
          root <= root_n;
`endif
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; results are published on the edge that leaves RUN or ERR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_load_x    <= 1'b0;
      o_load_y    <= 1'b0;
      o_ready     <= 1'b0;
      o_error     <= 1'b0;
      o_result    <= '0;
      o_remainder <= '0;
    end else begin
      o_load_x <= (state_d == LOAD_X);
      o_load_y <= (state_d == LOAD_Y);
      o_ready  <= (state_d == DONE);
      if (state == IDLE && i_start) o_error <= 1'b0;
      else if (state == ERR)        o_error <= 1'b1;
      if (state == ERR) begin
        o_result    <= '0;
        o_remainder <= '0;
      end else if (state == RUN && last) begin
        case (op)
          OP_MUL: begin
            o_result    <= acc_n;
            o_remainder <= '0;
          end
          OP_DIV: begin
            o_result    <= {DW'(0), acc_n[DW-1:0]};
            o_remainder <= rem_n;
          end
`ifdef MDR_ROOT_EN
          OP_ROOT: begin
            o_result    <= (2*DW)'(root_n);
            o_remainder <= rem_n;
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule
